sram_rw_arbiter: RTL and testbench

- Shares one single-port read/write SRAM macro (512 x 64, byte write mask, 1-cycle registered-address read) between two requesters.
- Round-robin arbitration, one access granted per cycle.
- After reset, or on request, a built-in sweep zeroes every entry, so the cache/scratch array never exposes random power-up contents.
- Sits between the L1/scratchpad access logic and the `*_ext` SRAM macro.

---
 rtl/sram_rw_arbiter_pkg.sv | 21 ++
 rtl/sram_rw_arbiter_if.sv | 36 +++
 rtl/sram_rw_arbiter_rr_arb2.sv | 26 ++
 rtl/sram_rw_arbiter.sv | 114 +++++++++++
 tb/tb_sram_rw_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_rw_arbiter_pkg.sv
// Shared types and default sizing for the SRAM read/write arbiter.
package sram_arb_pkg;

    localparam int unsigned DEPTH_DEF  = 512;
    localparam int unsigned ADDR_W_DEF = 9;
    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned MASK_W_DEF = DATA_W_DEF / 8;

    typedef enum logic {
        INIT = 1'b0,
        ARB  = 1'b1
    } state_e;

    typedef struct packed {
        logic                  write;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
        logic [MASK_W_DEF-1:0] wmask;
    } req_t;

endpackage

// File: rtl/sram_rw_arbiter_if.sv
// Requester handshake and SRAM macro bus seen by the arbiter.
interface sram_rw_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned MASK_W = MASK_W_DEF
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_write;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [2*MASK_W-1:0] req_wmask;
    logic [1:0]          resp_valid;
    logic [DATA_W-1:0]   resp_rdata;

    logic                sram_en;
    logic                sram_wmode;
    logic [ADDR_W-1:0]   sram_addr;
    logic [MASK_W-1:0]   sram_wmask;
    logic [DATA_W-1:0]   sram_wdata;
    logic [DATA_W-1:0]   sram_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wmask, sram_rdata,
        output req_ready, resp_valid, resp_rdata,
               sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wmask, sram_rdata,
        input  req_ready, resp_valid, resp_rdata,
               sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata
    );
endinterface

// File: rtl/sram_rw_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester favoured on a tie.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] valid_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);
    logic ptr_q, ptr_d;

    always_comb begin
        grant_o = '0;
        if (&valid_i) grant_o[ptr_q] = 1'b1;
        else          grant_o = valid_i;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && |grant_o) ptr_d = ~grant_o[1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= 1'b0;
        else         ptr_q <= ptr_d;
    end
endmodule

// File: rtl/sram_rw_arbiter.sv
// Shares one single-port SRAM between two requesters and zeroes it after reset
// or on init_req.
module sram_rw_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned MASK_W = MASK_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             init_req,
    output logic             init_done,
    sram_rw_arbiter_if.slave bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_addr_q, init_addr_d;
    logic [1:0]        resp_valid_q, resp_valid_d;
    logic [1:0]        arb_valid, grant;
    logic              sel;
    req_t              req [2];

    logic              en, wmode;
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] wdata;

    // init_req wins over requests, so the arbiter sees nothing that cycle
    assign arb_valid = (state_q == ARB && !init_req) ? bus.req_valid : 2'b00;
    assign sel       = grant[1];

    rr_arb2 u_rr_arb2 (
        .clk_i    (clock),
        .rst_ni   (reset_n),
        .valid_i  (arb_valid),
        .advance_i(state_q == ARB),
        .grant_o  (grant)
    );

    always_comb begin
        for (int unsigned k = 0; k < 2; k++) begin
            req[k].write = bus.req_write[k];
            req[k].addr  = bus.req_addr[k*ADDR_W +: ADDR_W];
            req[k].wdata = bus.req_wdata[k*DATA_W +: DATA_W];
            req[k].wmask = bus.req_wmask[k*MASK_W +: MASK_W];
        end
    end

    always_comb begin
        state_d      = state_q;
        init_addr_d  = init_addr_q;
        resp_valid_d = grant & ~bus.req_write;
        en           = 1'b0;
        wmode        = 1'b0;
        addr         = '0;
        wmask        = '0;
        wdata        = '0;
        case (state_q)
            INIT: begin
                en    = 1'b1;
                wmode = 1'b1;
                wmask = '1;
                addr  = init_addr_q;
                if (init_addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d     = ARB;
                    init_addr_d = '0;
                end else begin
                    init_addr_d = init_addr_q + 1'b1;
                end
            end
            ARB: begin
                if (init_req) begin
                    state_d = INIT;
                end else if (|grant) begin
                    en    = 1'b1;
                    wmode = req[sel].write;
                    addr  = req[sel].addr;
                    wmask = req[sel].wmask;
                    wdata = req[sel].wdata;
                end
            end
            default: state_d = INIT;
        endcase
        // SRAM strobes are combinational, so hold them quiet while reset is asserted
        if (!reset_n) begin
            en    = 1'b0;
            wmode = 1'b0;
            wmask = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= INIT;
            init_addr_q  <= '0;
            resp_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            init_addr_q  <= init_addr_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign init_done      = (state_q == ARB);
    assign bus.req_ready  = grant;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = bus.sram_rdata;
    assign bus.sram_en    = en;
    assign bus.sram_wmode = wmode;
    assign bus.sram_addr  = addr;
    assign bus.sram_wmask = wmask;
    assign bus.sram_wdata = wdata;
endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Scoreboard bench for sram_rw_arbiter with a behavioural 512x64 SRAM macro.
module tb_sram_rw_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic init_req = 1'b0;
    logic init_done;

    sram_rw_arbiter_if #(.ADDR_W(9), .DATA_W(64), .MASK_W(8)) bus ();

    sram_rw_arbiter #(.DEPTH(512), .ADDR_W(9), .DATA_W(64), .MASK_W(8)) dut (
        .clock    (clk),
        .reset_n  (rst_n),
        .init_req (init_req),
        .init_done(init_done),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [512];
    logic [63:0] rdata_q = '0;
    assign bus.sram_rdata = rdata_q;

    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_wmode) begin
                for (int b = 0; b < 8; b++)
                    if (bus.sram_wmask[b]) mem[bus.sram_addr][b*8 +: 8] <= bus.sram_wdata[b*8 +: 8];
            end else begin
                rdata_q <= mem[bus.sram_addr];
            end
        end
    end

    typedef struct {
        int          k;
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t        sb [$];
    logic [63:0] ref_mem [512];
    bit          ptr_m = 1'b0;
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [1:0]  erv;
        logic [63:0] ed;
        exp_t        e;
        erv = '0;
        ed  = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            erv[e.k] = 1'b1;
            ed = e.data;
        end
        n_assert++;
        if (bus.resp_valid !== erv) begin
            n_fail++;
            $display("FAIL resp_valid cyc=%0d: got %b expected %b", cyc, bus.resp_valid, erv);
        end
        if (erv != 2'b00) begin
            n_assert++;
            if (bus.resp_rdata !== ed) begin
                n_fail++;
                $display("FAIL resp_rdata cyc=%0d: got %h expected %h", cyc, bus.resp_rdata, ed);
            end
        end
    end

    task automatic drive(input logic [1:0] v, input logic [1:0] wr,
                         input logic [8:0] a0, input logic [8:0] a1,
                         input logic [63:0] d0, input logic [63:0] d1,
                         input logic [7:0] m0, input logic [7:0] m1);
        bus.req_valid = v;
        bus.req_write = wr;
        bus.req_addr  = {a1, a0};
        bus.req_wdata = {d1, d0};
        bus.req_wmask = {m1, m0};
    endtask

    function automatic logic [1:0] model_grant(input logic [1:0] v);
        if (v == 2'b11) return ptr_m ? 2'b10 : 2'b01;
        return v;
    endfunction

    task automatic model_commit(input logic [1:0] g);
        int         k;
        logic [8:0] a;
        exp_t       e;
        if (g == 2'b00) return;
        k = g[1] ? 1 : 0;
        a = bus.req_addr[k*9 +: 9];
        if (bus.req_write[k]) begin
            for (int b = 0; b < 8; b++)
                if (bus.req_wmask[k*8 + b]) ref_mem[a][b*8 +: 8] = bus.req_wdata[k*64 + b*8 +: 8];
        end else begin
            e.k    = k;
            e.data = ref_mem[a];
            e.due  = cyc + 1;
            sb.push_back(e);
        end
        ptr_m = (k == 0);
    endtask

    task automatic test_reset();
        logic [84:0] got, exp;
        #1 rst_n = 1'b0;
        #1;
        got = {bus.sram_en, bus.sram_wmode, bus.sram_addr, bus.sram_wmask, bus.sram_wdata};
        n_assert++;
        if (got !== '0 || bus.req_ready !== 2'b00 || bus.resp_valid !== 2'b00 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got sram=%h ready=%b resp=%b done=%b expected all zero",
                     got, bus.req_ready, bus.resp_valid, init_done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 512; i++) begin
            #1;
            got = {bus.sram_en, bus.sram_wmode, bus.sram_addr, bus.sram_wmask, bus.sram_wdata, bus.req_ready, init_done};
            exp = {1'b1, 1'b1, 9'(i), 8'hFF, 64'h0, 2'b00, 1'b0};
            n_assert++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_sweep i=%0d: got %h expected %h", i, got, exp);
            end
            @(negedge clk);
        end
        #1;
        n_assert++;
        if (init_done !== 1'b1 || bus.sram_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done: got done=%b en=%b expected done=1 en=0", init_done, bus.sram_en);
        end
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
    endtask

    task automatic test_single_requester();
        logic [1:0] g;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(2'b10, 2'b00, 9'd0, 9'(10 + i), '0, '0, '0, '0);
            #1;
            g = model_grant(bus.req_valid);
            n_assert++;
            if (bus.req_ready !== 2'b10 || g !== 2'b10) begin
                n_fail++;
                $display("FAIL single_req1 i=%0d: got ready %b expected 10", i, bus.req_ready);
            end
            model_commit(g);
        end
        @(negedge clk);
        drive(2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic test_write_read();
        @(negedge clk);
        drive(2'b01, 2'b01, 9'd5, 9'd0, 64'hDEADBEEF_CAFEF00D, '0, 8'h0F, '0);
        #1;
        n_assert++;
        if (bus.req_ready !== 2'b01 || bus.sram_en !== 1'b1 || bus.sram_wmode !== 1'b1 ||
            bus.sram_addr !== 9'd5 || bus.sram_wmask !== 8'h0F || bus.sram_wdata !== 64'hDEADBEEF_CAFEF00D) begin
            n_fail++;
            $display("FAIL wr_grant: got ready=%b en=%b wm=%b addr=%0d mask=%h expected 01 1 1 5 0f",
                     bus.req_ready, bus.sram_en, bus.sram_wmode, bus.sram_addr, bus.sram_wmask);
        end
        model_commit(model_grant(bus.req_valid));
        @(negedge clk);
        drive(2'b01, 2'b00, 9'd5, 9'd0, '0, '0, '0, '0);
        #1;
        n_assert++;
        if (bus.req_ready !== 2'b01 || bus.sram_wmode !== 1'b0 || bus.sram_addr !== 9'd5) begin
            n_fail++;
            $display("FAIL rd_grant: got ready=%b wm=%b addr=%0d expected 01 0 5",
                     bus.req_ready, bus.sram_wmode, bus.sram_addr);
        end
        model_commit(model_grant(bus.req_valid));
        @(negedge clk);
        n_assert++;
        if (bus.resp_valid !== 2'b01 || bus.resp_rdata !== 64'h00000000_CAFEF00D) begin
            n_fail++;
            $display("FAIL rd_data: got valid=%b data=%h expected 01 00000000cafef00d",
                     bus.resp_valid, bus.resp_rdata);
        end
        drive(2'b10, 2'b10, 9'd0, 9'd6, '0, 64'h01234567_89ABCDEF, '0, 8'hFF);
        #1;
        n_assert++;
        if (bus.req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL wr1_grant: got ready %b expected 10", bus.req_ready);
        end
        model_commit(model_grant(bus.req_valid));
        @(negedge clk);
        drive(2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
        #1;
        n_assert++;
        if (bus.req_ready !== 2'b00 || bus.sram_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle: got ready=%b en=%b expected 00 0", bus.req_ready, bus.sram_en);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(2'b11, 2'b00, 9'd5, 9'd6, '0, '0, '0, '0);
            #1;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_assert++;
            if (bus.req_ready !== exp_g || bus.sram_addr !== ((i % 2 == 0) ? 9'd5 : 9'd6)) begin
                n_fail++;
                $display("FAIL rr_grant i=%0d: got ready %b addr %0d expected %b", i, bus.req_ready, bus.sram_addr, exp_g);
            end
            model_commit(exp_g);
        end
        @(negedge clk);
        drive(2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic test_init_collision();
        logic [84:0] got, exp;
        @(negedge clk);
        drive(2'b11, 2'b00, 9'd5, 9'd6, '0, '0, '0, '0);
        init_req = 1'b1;
        #1;
        n_assert++;
        if (bus.req_ready !== 2'b00 || bus.sram_en !== 1'b0 || init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL init_prio: got ready=%b en=%b done=%b expected 00 0 1", bus.req_ready, bus.sram_en, init_done);
        end
        @(negedge clk);
        init_req = 1'b0;
        for (int i = 0; i < 512; i++) begin
            init_req = (i == 100);
            if (i == 511) drive(2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
            #1;
            got = {bus.sram_en, bus.sram_wmode, bus.sram_addr, bus.sram_wmask, bus.sram_wdata, bus.req_ready, init_done};
            exp = {1'b1, 1'b1, 9'(i), 8'hFF, 64'h0, 2'b00, 1'b0};
            n_assert++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL init_sweep i=%0d: got %h expected %h", i, got, exp);
            end
            @(negedge clk);
        end
        init_req = 1'b0;
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        drive(2'b01, 2'b00, 9'd5, '0, '0, '0, '0, '0);
        #1;
        n_assert++;
        if (init_done !== 1'b1 || bus.req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL post_init_grant: got done=%b ready=%b expected 1 01", init_done, bus.req_ready);
        end
        model_commit(model_grant(bus.req_valid));
        @(negedge clk);
        drive(2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_sweep();
        logic [84:0] got, exp;
        @(negedge clk);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        for (int i = 0; i <= 200; i++) begin
            #1;
            n_assert++;
            if (bus.sram_addr !== 9'(i) || bus.sram_en !== 1'b1) begin
                n_fail++;
                $display("FAIL mid_sweep i=%0d: got addr %0d en %b expected %0d 1", i, bus.sram_addr, bus.sram_en, i);
            end
            if (i < 200) @(negedge clk);
        end
        rst_n = 1'b0;
        sb.delete();
        ptr_m = 1'b0;
        #1;
        got = {bus.sram_en, bus.sram_wmode, bus.sram_addr, bus.sram_wmask, bus.sram_wdata};
        n_assert++;
        if (got !== '0 || bus.req_ready !== 2'b00 || bus.resp_valid !== 2'b00 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got sram=%h ready=%b resp=%b done=%b expected all zero",
                     got, bus.req_ready, bus.resp_valid, init_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 512; i++) begin
            #1;
            got = {bus.sram_en, bus.sram_wmode, bus.sram_addr, bus.sram_wmask, bus.sram_wdata, bus.req_ready, init_done};
            exp = {1'b1, 1'b1, 9'(i), 8'hFF, 64'h0, 2'b00, 1'b0};
            n_assert++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL restart_sweep i=%0d: got %h expected %h", i, got, exp);
            end
            @(negedge clk);
        end
        #1;
        n_assert++;
        if (init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_done: got %b expected 1", init_done);
        end
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        @(negedge clk);
        drive(2'b11, 2'b00, 9'd6, 9'd7, '0, '0, '0, '0);
        #1;
        n_assert++;
        if (bus.req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL ptr_after_reset: got ready %b expected 01", bus.req_ready);
        end
        model_commit(model_grant(bus.req_valid));
        @(negedge clk);
        drive(2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 64'hA5A5_5A5A_0000_0000 | 64'(i);
        drive(2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
        test_reset();
        test_single_requester();
        test_write_read();
        test_round_robin();
        test_init_collision();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
